lfsr_prbs_check: RTL and testbench

Self-synchronising PRBS checker that consumes the parallel word stream produced by `lfsr_prbs`, either looped back directly or after a serdes/link. It predicts each received bit from previously received bits using the LFSR recurrence and flags mismatches. It tracks lock with a PRIME/HUNT/LOCKED state machine and keeps saturating word-error and bit-error counters for link BER measurement.

---
 rtl/lfsr_prbs_check.sv | 202 ++++++++++++++++++++
 tb/tb_lfsr_prbs_check.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_check.sv
// Self-synchronising PRBS checker: predicts each received bit from earlier received
// bits via the LFSR recurrence, tracks lock and keeps saturating error counters.
module lfsr_prbs_check #(
   parameter int                    LFSR_WIDTH   = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
   parameter bit                    REVERSE      = 1'b0,
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    LOCK_COUNT   = 4,
   parameter int                    UNLOCK_COUNT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  error_valid,
   output logic [DATA_WIDTH-1:0] error_out,
   output logic                  locked,
   output logic [31:0]           word_err_count,
   output logic [31:0]           bit_err_count
);

   localparam int STREAM_W    = LFSR_WIDTH + DATA_WIDTH;
   localparam int PCNT_W      = $clog2(DATA_WIDTH + 1);
   localparam int PRIME_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int PRIME_W     = $clog2(PRIME_WORDS + 1);
   localparam int LOCK_W      = $clog2(LOCK_COUNT + 1);
   localparam int UNLOCK_W    = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic [1:0] {
      ST_PRIME  = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[32]) begin
         return 32'hFFFF_FFFF;
      end else begin
         return sum[31:0];
      end
   endfunction

   state_e                state_q, state_d;
   logic [LFSR_WIDTH-1:0] hist_q, hist_d;
   logic [PRIME_W-1:0]    prime_cnt_q, prime_cnt_d;
   logic [LOCK_W-1:0]     clean_cnt_q, clean_cnt_d;
   logic [UNLOCK_W-1:0]   unlock_cnt_q, unlock_cnt_d;
   logic                  err_valid_q, err_valid_d;
   logic [DATA_WIDTH-1:0] err_out_q, err_out_d;
   logic                  locked_q, locked_d;
   logic [31:0]           word_err_q, word_err_d;
   logic [31:0]           bit_err_q, bit_err_d;

   logic [DATA_WIDTH-1:0] word_t_s;
   logic [DATA_WIDTH-1:0] err_t_s;
   logic [DATA_WIDTH-1:0] err_s;
   logic [STREAM_W-1:0]   stream_s;
   logic [PCNT_W-1:0]     pcnt_s;
   logic                  err_any_s;
   logic                  word_zero_s;

   // Reorder the word so index 0 is the earliest bit in time.
   always_comb begin
      word_t_s = {DATA_WIDTH{1'b0}};
      for (int t = 0; t < DATA_WIDTH; t++) begin
         if (REVERSE) begin
            word_t_s[t] = data_in[t];
         end else begin
            word_t_s[t] = data_in[DATA_WIDTH-1-t];
         end
      end
   end

   // Oldest bits at index 0; taps for bit t of the word start at stream_s[t].
   assign stream_s = {word_t_s, hist_q};

   // Predict from received bits only, so in-word taps use the raw data.
   always_comb begin
      err_t_s = {DATA_WIDTH{1'b0}};
      err_s   = {DATA_WIDTH{1'b0}};
      pcnt_s  = {PCNT_W{1'b0}};
      for (int t = 0; t < DATA_WIDTH; t++) begin
         err_t_s[t] = word_t_s[t] ^ (^(stream_s[t +: LFSR_WIDTH] & LFSR_POLY));
         pcnt_s     = pcnt_s + PCNT_W'(err_t_s[t]);
      end
      for (int k = 0; k < DATA_WIDTH; k++) begin
         if (REVERSE) begin
            err_s[k] = err_t_s[k];
         end else begin
            err_s[k] = err_t_s[DATA_WIDTH-1-k];
         end
      end
   end

   assign err_any_s   = |err_t_s;
   assign word_zero_s = (data_in == {DATA_WIDTH{1'b0}});

   // Lock state machine, history update and error counters.
   always_comb begin
      state_d      = state_q;
      hist_d       = hist_q;
      prime_cnt_d  = prime_cnt_q;
      clean_cnt_d  = clean_cnt_q;
      unlock_cnt_d = unlock_cnt_q;
      err_valid_d  = 1'b0;
      err_out_d    = {DATA_WIDTH{1'b0}};
      word_err_d   = word_err_q;
      bit_err_d    = bit_err_q;
      if (data_valid) begin
         err_valid_d = 1'b1;
         hist_d      = stream_s[DATA_WIDTH +: LFSR_WIDTH];
         case (state_q)
            ST_PRIME: begin
               if (prime_cnt_q == PRIME_W'(PRIME_WORDS - 1)) begin
                  state_d     = ST_HUNT;
                  prime_cnt_d = {PRIME_W{1'b0}};
               end else begin
                  prime_cnt_d = prime_cnt_q + PRIME_W'(1);
               end
            end
            ST_HUNT: begin
               err_out_d = err_s;
               // An all-zero word is never accepted as clean: zero is a fixed point.
               if (err_any_s || word_zero_s) begin
                  clean_cnt_d = {LOCK_W{1'b0}};
               end else if (clean_cnt_q == LOCK_W'(LOCK_COUNT - 1)) begin
                  state_d      = ST_LOCKED;
                  clean_cnt_d  = {LOCK_W{1'b0}};
                  unlock_cnt_d = {UNLOCK_W{1'b0}};
               end else begin
                  clean_cnt_d = clean_cnt_q + LOCK_W'(1);
               end
            end
            ST_LOCKED: begin
               err_out_d = err_s;
               bit_err_d = sat_add32(bit_err_q, 32'(pcnt_s));
               if (err_any_s) begin
                  word_err_d = sat_add32(word_err_q, 32'd1);
                  if (unlock_cnt_q == UNLOCK_W'(UNLOCK_COUNT - 1)) begin
                     state_d      = ST_HUNT;
                     unlock_cnt_d = {UNLOCK_W{1'b0}};
                     clean_cnt_d  = {LOCK_W{1'b0}};
                  end else begin
                     unlock_cnt_d = unlock_cnt_q + UNLOCK_W'(1);
                  end
               end else begin
                  unlock_cnt_d = {UNLOCK_W{1'b0}};
               end
            end
            default: begin
               state_d = ST_PRIME;
            end
         endcase
      end else begin
         err_valid_d = 1'b0;
      end
      if (clear) begin
         word_err_d = 32'd0;
         bit_err_d  = 32'd0;
      end else begin
         word_err_d = word_err_d;
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_PRIME;
         hist_q       <= {LFSR_WIDTH{1'b0}};
         prime_cnt_q  <= {PRIME_W{1'b0}};
         clean_cnt_q  <= {LOCK_W{1'b0}};
         unlock_cnt_q <= {UNLOCK_W{1'b0}};
         err_valid_q  <= 1'b0;
         err_out_q    <= {DATA_WIDTH{1'b0}};
         locked_q     <= 1'b0;
         word_err_q   <= 32'd0;
         bit_err_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         prime_cnt_q  <= prime_cnt_d;
         clean_cnt_q  <= clean_cnt_d;
         unlock_cnt_q <= unlock_cnt_d;
         err_valid_q  <= err_valid_d;
         err_out_q    <= err_out_d;
         locked_q     <= locked_d;
         word_err_q   <= word_err_d;
         bit_err_q    <= bit_err_d;
      end
   end

   assign error_valid    = err_valid_q;
   assign error_out      = err_out_q;
   assign locked         = locked_q;
   assign word_err_count = word_err_q;
   assign bit_err_count  = bit_err_q;

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Directed-plus-random bench for lfsr_prbs_check against a bit-serial reference model.
module tb_lfsr_prbs_check;

   localparam int          LW      = 31;
   localparam int          DW      = 64;
   localparam logic [30:0] POLY    = 31'h10000001;
   localparam int          LOCKN   = 4;
   localparam int          UNLOCKN = 8;
   localparam int          PRIME_N = (LW + DW - 1) / DW;
   localparam longint      MAXC    = 64'h0000_0000_FFFF_FFFF;

   logic          clk;
   logic          rst_n;
   logic          clear;
   logic [DW-1:0] data_in;
   logic          data_valid;
   logic          error_valid;
   logic [DW-1:0] error_out;
   logic          locked;
   logic [31:0]   word_err_count;
   logic [31:0]   bit_err_count;

   int tests = 0;
   int fails = 0;

   lfsr_prbs_check dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .data_in        (data_in),
      .data_valid     (data_valid),
      .error_valid    (error_valid),
      .error_out      (error_out),
      .locked         (locked),
      .word_err_count (word_err_count),
      .bit_err_count  (bit_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PRBS source: b[n] = b[n-31] ^ b[n-3], seeded with all ones
   bit gen_q[$];
   // Reference: last 31 received bits, oldest first
   bit rx_q[$];
   int          m_mode;   // 0 prime, 1 hunt, 2 locked
   int          m_words, m_clean, m_bad;
   longint      m_wec, m_bec;
   logic [63:0] m_mask;

   function automatic logic [63:0] gen_word();
      logic [63:0] w;
      bit nb;
      w = 64'd0;
      for (int t = 0; t < DW; t++) begin
         nb = gen_q[0] ^ gen_q[28];
         gen_q.push_back(nb);
         void'(gen_q.pop_front());
         w[DW-1-t] = nb;
      end
      return w;
   endfunction

   function automatic void model_reset();
      rx_q.delete();
      for (int i = 0; i < LW; i++) rx_q.push_back(1'b0);
      m_mode = 0; m_words = 0; m_clean = 0; m_bad = 0;
      m_wec = 0; m_bec = 0; m_mask = 64'd0;
   endfunction

   function automatic void model_word(input logic [63:0] d, input logic clr);
      logic [63:0] mask;
      int pc;
      bit rb, p;
      mask = 64'd0;
      pc = 0;
      for (int t = 0; t < DW; t++) begin
         rb = d[DW-1-t];
         p = 1'b0;
         for (int i = 0; i < LW; i++) if (POLY[i]) p = p ^ rx_q[i];
         rx_q.push_back(rb);
         void'(rx_q.pop_front());
         mask[DW-1-t] = rb ^ p;
         if ((rb ^ p) == 1'b1) pc++;
      end
      if (m_mode == 0) begin
         m_mask = 64'd0;
         m_words++;
         if (m_words == PRIME_N) m_mode = 1;
      end else if (m_mode == 1) begin
         m_mask = mask;
         if (mask != 64'd0 || d == 64'd0) m_clean = 0;
         else begin
            m_clean++;
            if (m_clean == LOCKN) begin m_mode = 2; m_bad = 0; end
         end
      end else begin
         m_mask = mask;
         m_bec = (m_bec + pc > MAXC) ? MAXC : m_bec + pc;
         if (mask != 64'd0) begin
            m_wec = (m_wec + 1 > MAXC) ? MAXC : m_wec + 1;
            m_bad++;
            if (m_bad == UNLOCKN) begin m_mode = 1; m_clean = 0; end
         end else m_bad = 0;
      end
      if (clr) begin m_wec = 0; m_bec = 0; end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at negedge, then check all outputs just after the posedge.
   task automatic step(input logic v, input logic [63:0] d, input logic clr);
      @(negedge clk);
      data_valid = v; data_in = d; clear = clr;
      @(posedge clk);
      #1;
      if (v) begin
         model_word(d, clr);
         chk("error_valid", {63'd0, error_valid}, 64'd1);
         chk("error_out", error_out, m_mask);
         chk("locked", {63'd0, locked}, {63'd0, m_mode == 2});
      end else begin
         if (clr) begin m_wec = 0; m_bec = 0; end
         chk("error_valid_idle", {63'd0, error_valid}, 64'd0);
      end
      chk("word_err_count", {32'd0, word_err_count}, 64'(m_wec));
      chk("bit_err_count", {32'd0, bit_err_count}, 64'(m_bec));
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ev"}, {63'd0, error_valid}, 64'd0);
      chk({tag, "_eo"}, error_out, 64'd0);
      chk({tag, "_lk"}, {63'd0, locked}, 64'd0);
      chk({tag, "_wec"}, {32'd0, word_err_count}, 64'd0);
      chk({tag, "_bec"}, {32'd0, bit_err_count}, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; data_valid = 1'b0; clear = 1'b0; data_in = 64'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] d;
      logic [63:0] exp_m;
      for (int i = 0; i < LW; i++) gen_q.push_back(1'b1);

      // Reset and lock acquisition: PRIME on word 1, locked with word 5
      do_reset();
      for (int w = 1; w <= 1000; w++) begin
         step(1'b1, gen_word(), 1'b0);
         if (w == 1) chk("prime_mask", error_out, 64'd0);
         if (w == 4) chk("unlocked_w4", {63'd0, locked}, 64'd0);
         if (w == 5) chk("locked_w5", {63'd0, locked}, 64'd1);
      end
      chk("clean_wec", {32'd0, word_err_count}, 64'd0);
      chk("clean_bec", {32'd0, bit_err_count}, 64'd0);

      // Single-bit error at data_in[40]
      step(1'b0, 64'd0, 1'b1);
      d = gen_word(); d[40] = ~d[40];
      step(1'b1, d, 1'b0);
      exp_m = 64'd0; exp_m[40] = 1'b1; exp_m[37] = 1'b1; exp_m[9] = 1'b1;
      chk("single_mask", error_out, exp_m);
      chk("single_wec", {32'd0, word_err_count}, 64'd1);
      chk("single_bec", {32'd0, bit_err_count}, 64'd3);
      chk("single_locked", {63'd0, locked}, 64'd1);
      step(1'b1, gen_word(), 1'b0);
      chk("single_next", error_out, 64'd0);

      // Loss of lock: 8 words with bit 0 flipped
      step(1'b0, 64'd0, 1'b1);
      for (int w = 1; w <= UNLOCKN; w++) begin
         d = gen_word(); d[0] = ~d[0];
         step(1'b1, d, 1'b0);
         if (w == UNLOCKN - 1) chk("still_locked", {63'd0, locked}, 64'd1);
      end
      chk("unlock_fall", {63'd0, locked}, 64'd0);
      chk("unlock_wec", {32'd0, word_err_count}, 64'd8);
      // The first word after the burst still carries the echoes of the last flip
      for (int w = 1; w <= 5; w++) begin
         step(1'b1, gen_word(), 1'b0);
         if (w == 4) chk("relock_w4", {63'd0, locked}, 64'd0);
      end
      chk("relock_w5", {63'd0, locked}, 64'd1);

      // Saturation of bit_err_count and clear collision
      step(1'b1, gen_word(), 1'b0);
      #1 force dut.bit_err_q = 32'hFFFF_FFFE;
      #1 release dut.bit_err_q;
      m_bec = 64'h0000_0000_FFFF_FFFE;
      d = gen_word(); d[40] = ~d[40];
      step(1'b1, d, 1'b0);
      chk("sat_bec", {32'd0, bit_err_count}, 64'h0000_0000_FFFF_FFFF);
      d = gen_word(); d[20] = ~d[20];
      step(1'b1, d, 1'b0);
      chk("sat_hold", {32'd0, bit_err_count}, 64'h0000_0000_FFFF_FFFF);
      d = gen_word(); d[5] = ~d[5];
      step(1'b1, d, 1'b1);
      chk("clear_wec", {32'd0, word_err_count}, 64'd0);
      chk("clear_bec", {32'd0, bit_err_count}, 64'd0);
      chk("clear_keeps_lock", {63'd0, locked}, 64'd1);

      // Zero stream never locks
      do_reset();
      for (int w = 0; w < 20; w++) step(1'b1, 64'd0, 1'b0);
      chk("zero_locked", {63'd0, locked}, 64'd0);
      chk("zero_wec", {32'd0, word_err_count}, 64'd0);

      // Random gaps, sparse random bit errors and occasional clear
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            d = gen_word();
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 63)] ^= 1'b1;
            step(1'b1, d, ($urandom_range(0, 31) == 0));
         end else begin
            step(1'b0, 64'(($urandom() << 32) | $urandom()), 1'b0);
         end
      end
      for (int w = 0; w < 10; w++) step(1'b1, gen_word(), 1'b0);
      chk("pre_reset_locked", {63'd0, locked}, 64'd1);

      // Asynchronous reset mid-stream, then reacquire
      @(negedge clk);
      data_valid = 1'b1; data_in = gen_word();
      #2 rst_n = 1'b0;
      #1;
      chk_zero_outputs("async");
      data_valid = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int w = 1; w <= 5; w++) begin
         step(1'b1, gen_word(), 1'b0);
         if (w == 4) chk("reacq_w4", {63'd0, locked}, 64'd0);
      end
      chk("reacq_w5", {63'd0, locked}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
